// File: rtl/multi_dma_rc_pkg.sv
// Shared types for the multi-channel DMA descriptor scheduler.
package multi_dma_rc_pkg;

  // One read descriptor: byte address and byte length.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] len;
  } dma_desc_t;

  // Scheduler FSM: scan, write address, write length (which starts the channel).
  typedef enum logic [1:0] {
    IDLE,
    WADR,
    WLEN
  } sched_st_e;

endpackage

// File: rtl/multi_dma_rc_sched_if.sv
// Descriptor push channel between an upstream agent and the scheduler.
interface multi_dma_rc_sched_if #(
  parameter int unsigned CW = 3
) ();

  logic          desc_val;
  logic          desc_rdy;
  logic [CW-1:0] desc_ch;
  logic [31:0]   desc_adr;
  logic [31:0]   desc_len;
  logic          desc_drop;

  modport master (
    output desc_val, desc_ch, desc_adr, desc_len,
    input  desc_rdy, desc_drop
  );

  modport slave (
    input  desc_val, desc_ch, desc_adr, desc_len,
    output desc_rdy, desc_drop
  );

endinterface

// File: rtl/multi_dma_rc_dq.sv
// Per-channel descriptor queue: synchronous FIFO with show-ahead head.
module multi_dma_rc_dq #(
  parameter int unsigned W  = 64,
  parameter int unsigned QW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned Depth = 2 ** QW;

  logic [W-1:0]  mem_q [Depth];
  logic [QW-1:0] wr_q;
  logic [QW-1:0] rd_q;
  logic [QW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (QW+1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q];

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + QW'(1);
      if (do_pop)  rd_q <= rd_q + QW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (QW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (QW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/multi_dma_rc_sched.sv
// Descriptor scheduler for the multi-channel burst DMA read engine: queues descriptors
// per channel, programs idle channels round-robin over the shared PIO port, tracks
// busy/completion and owns the engine's active channel count.
module multi_dma_rc_sched
  import multi_dma_rc_pkg::*;
#(
  parameter int unsigned CH = 5,
  parameter int unsigned CW = $clog2(CH),
  parameter int unsigned QW = 2,
  parameter int unsigned AL = 2,
  parameter int unsigned BL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_dma_rc_sched_if.slave  desc,
  input  logic [CW-1:0]        cfg_nch,
  output logic [CW-1:0]        nch,
  output logic [CH-1:0]        pio_adr_we,
  output logic [CH-1:0]        pio_len_we,
  output logic [31:0]          pio_d,
  input  logic [CH-1:0]        done,
  input  logic [CH-1:0]        err,
  output logic [CH-1:0]        busy,
  output logic                 cmpl_val,
  output logic [CW-1:0]        cmpl_ch,
  output logic                 cmpl_err
);

  localparam int unsigned   AW     = BL + AL;
  localparam logic [CW-1:0] NchMax = CW'(CH - 1);
  localparam logic [CH-1:0] ChOne  = CH'(1);

  sched_st_e     st_q;
  logic [CW-1:0] sel_q;
  logic [CW-1:0] rr_q;
  logic [CW-1:0] nch_q;
  logic [CH-1:0] busy_q;
  logic [CH-1:0] pio_adr_we_q;
  logic [CH-1:0] pio_len_we_q;
  logic [31:0]   pio_d_q;
  logic          cmpl_val_q;
  logic [CW-1:0] cmpl_ch_q;
  logic          cmpl_err_q;
  logic          drop_q;

  logic [CH-1:0] full;
  logic [CH-1:0] empty;
  logic [CH-1:0] push;
  logic [CH-1:0] pop;
  dma_desc_t     head [CH];
  dma_desc_t     wr_desc;

  logic          accept;
  logic          bad;
  logic          pick_vld;
  logic [CW-1:0] pick;
  logic [CW:0]   idx;
  logic [31:0]   pick_adr;
  logic [31:0]   sel_len;
  logic [CH-1:0] comp;
  logic [CW-1:0] comp_ch;
  logic          comp_err;
  logic [CW-1:0] nch_cfg;

  // Ready reflects the pre-pop fill of the addressed queue; out-of-range channels
  // are always accepted so they can be dropped.
  always_comb begin
    desc.desc_rdy = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (desc.desc_ch == CW'(c)) desc.desc_rdy = ~full[c];
    end
  end

  assign accept  = desc.desc_val & desc.desc_rdy;
  assign bad     = (desc.desc_ch > nch_q) | (|desc.desc_adr[AW-1:0]) |
                   (|desc.desc_len[AW-1:0]) | (desc.desc_len == '0);
  assign wr_desc = '{adr: desc.desc_adr, len: desc.desc_len};

  for (genvar c = 0; c < CH; c++) begin : g_q
    assign push[c] = accept & ~bad & (desc.desc_ch == CW'(c));
    assign pop[c]  = (st_q == WLEN) & (sel_q == CW'(c));

    multi_dma_rc_dq #(
      .W  ($bits(dma_desc_t)),
      .QW (QW)
    ) u_dq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata (wr_desc),
      .head  (head[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  // Round-robin pick: first eligible channel at or after rr_q, wrapping over CH.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int i = 0; i < CH; i++) begin
      idx = {1'b0, rr_q} + (CW+1)'(i);
      if (idx >= (CW+1)'(CH)) idx = idx - (CW+1)'(CH);
      if (!pick_vld && (idx[CW-1:0] <= nch_q) && !busy_q[idx[CW-1:0]] &&
          !empty[idx[CW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[CW-1:0];
      end
    end
  end

  // Head field muxes for the address (picked channel) and length (latched channel).
  always_comb begin
    pick_adr = '0;
    sel_len  = '0;
    for (int c = 0; c < CH; c++) begin
      if (pick == CW'(c))  pick_adr = head[c].adr;
      if (sel_q == CW'(c)) sel_len  = head[c].len;
    end
  end

  // Completions on busy channels; lowest index is the one reported.
  always_comb begin
    comp     = (done | err) & busy_q;
    comp_ch  = '0;
    comp_err = 1'b0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (comp[c]) begin
        comp_ch  = CW'(c);
        comp_err = err[c];
      end
    end
  end

  assign nch_cfg = (cfg_nch > NchMax) ? NchMax : cfg_nch;

  // Scheduler FSM with registered PIO strobes; length goes last since it starts the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= IDLE;
      sel_q        <= '0;
      rr_q         <= '0;
      pio_adr_we_q <= '0;
      pio_len_we_q <= '0;
      pio_d_q      <= '0;
    end else begin
      pio_adr_we_q <= '0;
      pio_len_we_q <= '0;
      pio_d_q      <= '0;
      unique case (st_q)
        IDLE: begin
          if (pick_vld) begin
            sel_q        <= pick;
            st_q         <= WADR;
            pio_adr_we_q <= ChOne << pick;
            pio_d_q      <= pick_adr;
          end
        end
        WADR: begin
          st_q         <= WLEN;
          pio_len_we_q <= ChOne << sel_q;
          pio_d_q      <= sel_len;
        end
        WLEN: begin
          st_q <= IDLE;
          rr_q <= (sel_q == nch_q) ? '0 : sel_q + CW'(1);
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // Busy tracking, completion record, drop pulse and nch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      cmpl_val_q <= 1'b0;
      cmpl_ch_q  <= '0;
      cmpl_err_q <= 1'b0;
      drop_q     <= 1'b0;
      nch_q      <= '0;
    end else begin
      busy_q     <= (busy_q & ~comp) | ((st_q == WLEN) ? (ChOne << sel_q) : '0);
      cmpl_val_q <= |comp;
      cmpl_ch_q  <= comp_ch;
      cmpl_err_q <= comp_err;
      drop_q     <= accept & bad;
      // Only retarget the engine when it is fully quiescent.
      if ((st_q == IDLE) && (busy_q == '0)) nch_q <= nch_cfg;
    end
  end

  assign desc.desc_drop = drop_q;
  assign nch            = nch_q;
  assign busy           = busy_q;
  assign pio_adr_we     = pio_adr_we_q;
  assign pio_len_we     = pio_len_we_q;
  assign pio_d          = pio_d_q;
  assign cmpl_val       = cmpl_val_q;
  assign cmpl_ch        = cmpl_ch_q;
  assign cmpl_err       = cmpl_err_q;

endmodule

// File: tb/tb_multi_dma_rc_sched.sv
// Directed bench for multi_dma_rc_sched.
module tb_multi_dma_rc_sched;

  localparam int unsigned CH = 5;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cfg_nch;
  logic [CW-1:0] nch;
  logic [CH-1:0] pio_adr_we;
  logic [CH-1:0] pio_len_we;
  logic [31:0]   pio_d;
  logic [CH-1:0] done;
  logic [CH-1:0] err;
  logic [CH-1:0] busy;
  logic          cmpl_val;
  logic [CW-1:0] cmpl_ch;
  logic          cmpl_err;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multi_dma_rc_sched_if #(.CW(CW)) dif ();

  multi_dma_rc_sched #(
    .CH (CH),
    .CW (CW),
    .QW (2),
    .AL (2),
    .BL (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .desc       (dif),
    .cfg_nch    (cfg_nch),
    .nch        (nch),
    .pio_adr_we (pio_adr_we),
    .pio_len_we (pio_len_we),
    .pio_d      (pio_d),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .cmpl_val   (cmpl_val),
    .cmpl_ch    (cmpl_ch),
    .cmpl_err   (cmpl_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] ch, input logic [31:0] a, input logic [31:0] l);
    dif.desc_val = 1'b1;
    dif.desc_ch  = ch;
    dif.desc_adr = a;
    dif.desc_len = l;
    tick;
    dif.desc_val = 1'b0;
  endtask

  // Observes the next programming sequence; returns at the length-write cycle.
  task automatic wait_prog(output int ch, output logic [31:0] a, output logic [CH-1:0] lwe,
                           output logic [31:0] l, output bit ok);
    ok = 0; ch = -1; a = '0; lwe = '0; l = '0;
    for (int i = 0; i < 30; i++) begin
      if (pio_adr_we != '0) begin
        for (int c = 0; c < CH; c++) if (pio_adr_we[c]) ch = c;
        a = pio_d;
        tick;
        lwe = pio_len_we;
        l   = pio_d;
        ok  = 1;
        break;
      end
      tick;
    end
  endtask

  task automatic wait_busy(input logic [CH-1:0] exp, output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy === exp) begin
        ok = 1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (nch !== 0 || busy !== 0 || pio_adr_we !== 0 || pio_len_we !== 0 || pio_d !== 0 ||
        cmpl_val !== 0 || cmpl_ch !== 0 || cmpl_err !== 0 || dif.desc_drop !== 0) begin
      errors++;
      $display("FAIL reset_state: nch=%0d busy=%b adr_we=%b len_we=%b d=%h cv=%b cc=%0d ce=%b dr=%b want all 0",
               nch, busy, pio_adr_we, pio_len_we, pio_d, cmpl_val, cmpl_ch, cmpl_err,
               dif.desc_drop);
    end
    vectors++;
    if (dif.desc_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: got %b want 1", dif.desc_rdy);
    end
  endtask

  task automatic test_basic;
    push(0, 32'h1000, 32'h100);
    vectors++;
    if (pio_adr_we !== 0 || dif.desc_drop !== 0) begin
      errors++;
      $display("FAIL basic_T0: adr_we=%b drop=%b want 0 0", pio_adr_we, dif.desc_drop);
    end
    tick;
    vectors++;
    if (pio_adr_we !== 5'b00001 || pio_len_we !== 0 || pio_d !== 32'h1000) begin
      errors++;
      $display("FAIL basic_adr: adr_we=%b len_we=%b d=%h want 00001 00000 1000",
               pio_adr_we, pio_len_we, pio_d);
    end
    tick;
    vectors++;
    if (pio_len_we !== 5'b00001 || pio_adr_we !== 0 || pio_d !== 32'h100) begin
      errors++;
      $display("FAIL basic_len: len_we=%b adr_we=%b d=%h want 00001 00000 100",
               pio_len_we, pio_adr_we, pio_d);
    end
    tick;
    vectors++;
    if (busy !== 5'b00001 || pio_len_we !== 0 || pio_d !== 0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b len_we=%b d=%h want 00001 0 0", busy, pio_len_we, pio_d);
    end
    done = 5'b00001;
    tick;
    done = '0;
    vectors++;
    if (cmpl_val !== 1 || cmpl_ch !== 0 || cmpl_err !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL basic_cmpl: cv=%b cc=%0d ce=%b busy=%b want 1 0 0 00000",
               cmpl_val, cmpl_ch, cmpl_err, busy);
    end
    tick;
    vectors++;
    if (cmpl_val !== 0) begin
      errors++;
      $display("FAIL basic_cmpl_pulse: cv=%b want 0", cmpl_val);
    end
  endtask

  task automatic test_round_robin;
    int ch; logic [31:0] a; logic [31:0] l; logic [CH-1:0] lwe; bit ok;
    int exp_ch [3] = '{0, 1, 2};
    cfg_nch = 2;
    tick;
    vectors++;
    if (nch !== 2) begin
      errors++;
      $display("FAIL rr_nch: got %0d want 2", nch);
    end
    push(0, 32'h4000, 32'h40);
    push(1, 32'h4100, 32'h40);
    push(2, 32'h4200, 32'h40);
    wait_busy(5'b00111, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_first_batch: busy=%b want 00111", busy);
    end
    // Queued behind busy channels; released together by one multi-completion.
    push(2, 32'h5200, 32'h80);
    push(0, 32'h5000, 32'h80);
    push(1, 32'h5100, 32'h80);
    done = 5'b00111;
    tick;
    done = '0;
    vectors++;
    if (cmpl_val !== 1 || cmpl_ch !== 0 || cmpl_err !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL rr_multi_cmpl: cv=%b cc=%0d ce=%b busy=%b want 1 0 0 00000",
               cmpl_val, cmpl_ch, cmpl_err, busy);
    end
    for (int k = 0; k < 3; k++) begin
      wait_prog(ch, a, lwe, l, ok);
      vectors++;
      if (!ok || ch != exp_ch[k] || a !== 32'h5000 + 32'(exp_ch[k]) * 32'h100 ||
          l !== 32'h80 || lwe !== (5'b00001 << exp_ch[k])) begin
        errors++;
        $display("FAIL rr_order%0d: ok=%0d ch=%0d adr=%h len=%h lwe=%b want ch %0d adr %h len 80",
                 k, ok, ch, a, l, lwe, exp_ch[k], 32'h5000 + 32'(exp_ch[k]) * 32'h100);
      end
    end
    err = 5'b00010;
    tick;
    err = '0;
    vectors++;
    if (cmpl_val !== 1 || cmpl_ch !== 1 || cmpl_err !== 1 || busy !== 5'b00101) begin
      errors++;
      $display("FAIL rr_err_cmpl: cv=%b cc=%0d ce=%b busy=%b want 1 1 1 00101",
               cmpl_val, cmpl_ch, cmpl_err, busy);
    end
    done = 5'b00101;
    tick;
    done = '0;
  endtask

  task automatic test_queue_full;
    int ch; logic [31:0] a; logic [31:0] l; logic [CH-1:0] lwe; bit ok;
    push(0, 32'h3000, 32'h40);
    wait_busy(5'b00001, ok);
    for (int i = 0; i < 4; i++) push(0, 32'h2000 + 32'(i) * 32'h40, 32'h40 * 32'(i + 1));
    dif.desc_val = 1'b1;
    dif.desc_ch  = 0;
    dif.desc_adr = 32'h2100;
    dif.desc_len = 32'h40;
    #1;
    vectors++;
    if (dif.desc_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy: got %b want 0", dif.desc_rdy);
    end
    dif.desc_ch = 1;
    #1;
    vectors++;
    if (dif.desc_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_other_rdy: got %b want 1", dif.desc_rdy);
    end
    dif.desc_ch = 6;
    #1;
    vectors++;
    if (dif.desc_rdy !== 1'b1) begin
      errors++;
      $display("FAIL range_rdy: got %b want 1", dif.desc_rdy);
    end
    dif.desc_val = 1'b0;
    dif.desc_ch  = 0;
    done = 5'b00001;
    tick;
    done = '0;
    for (int i = 0; i < 4; i++) begin
      wait_prog(ch, a, lwe, l, ok);
      vectors++;
      if (!ok || ch != 0 || a !== 32'h2000 + 32'(i) * 32'h40 || l !== 32'h40 * 32'(i + 1) ||
          lwe !== 5'b00001) begin
        errors++;
        $display("FAIL fifo_order%0d: ok=%0d ch=%0d adr=%h len=%h lwe=%b want ch 0 adr %h len %h",
                 i, ok, ch, a, l, lwe, 32'h2000 + 32'(i) * 32'h40, 32'h40 * 32'(i + 1));
      end
      tick;
      if (i == 0) begin
        vectors++;
        if (dif.desc_rdy !== 1'b1) begin
          errors++;
          $display("FAIL full_rdy_again: got %b want 1", dif.desc_rdy);
        end
      end
      done = 5'b00001;
      tick;
      done = '0;
    end
  endtask

  task automatic test_drops;
    bit quiet;
    cfg_nch = 1;
    tick;
    vectors++;
    if (nch !== 1) begin
      errors++;
      $display("FAIL drop_nch: got %0d want 1", nch);
    end
    push(0, 32'h1004, 32'h10);
    vectors++;
    if (dif.desc_drop !== 1) begin
      errors++;
      $display("FAIL drop_misaligned: drop=%b want 1", dif.desc_drop);
    end
    tick;
    vectors++;
    if (dif.desc_drop !== 0) begin
      errors++;
      $display("FAIL drop_pulse: drop=%b want 0", dif.desc_drop);
    end
    push(0, 32'h1000, 32'h0);
    vectors++;
    if (dif.desc_drop !== 1) begin
      errors++;
      $display("FAIL drop_len0: drop=%b want 1", dif.desc_drop);
    end
    tick;
    push(3, 32'h1000, 32'h40);
    vectors++;
    if (dif.desc_drop !== 1) begin
      errors++;
      $display("FAIL drop_ch_above_nch: drop=%b want 1", dif.desc_drop);
    end
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (pio_adr_we !== 0 || pio_len_we !== 0 || busy !== 0) quiet = 0;
    end
    vectors++;
    if (!quiet) begin
      errors++;
      $display("FAIL drop_no_pio: pio activity seen (adr_we=%b busy=%b) want none",
               pio_adr_we, busy);
    end
  endtask

  task automatic test_nch_update;
    bit ok;
    push(0, 32'h6000, 32'h40);
    wait_busy(5'b00001, ok);
    cfg_nch = 3;
    tick;
    tick;
    vectors++;
    if (nch !== 1) begin
      errors++;
      $display("FAIL nch_hold_busy: got %0d want 1", nch);
    end
    done = 5'b00001;
    tick;
    done = '0;
    vectors++;
    if (nch !== 1 || busy !== 0 || cmpl_val !== 1) begin
      errors++;
      $display("FAIL nch_done_edge: nch=%0d busy=%b cv=%b want 1 00000 1", nch, busy, cmpl_val);
    end
    tick;
    vectors++;
    if (nch !== 3) begin
      errors++;
      $display("FAIL nch_update: got %0d want 3", nch);
    end
    done = 5'b00010;
    tick;
    done = '0;
    vectors++;
    if (cmpl_val !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL spurious_done: cv=%b busy=%b want 0 00000", cmpl_val, busy);
    end
  endtask

  task automatic test_reset_midflight;
    bit ok;
    bit quiet;
    push(0, 32'h7000, 32'h40);
    wait_busy(5'b00001, ok);
    push(0, 32'h7040, 32'h40);
    push(0, 32'h7080, 32'h40);
    push(1, 32'h7100, 32'h40);
    tick;
    vectors++;
    if (pio_adr_we !== 5'b00010 || pio_d !== 32'h7100) begin
      errors++;
      $display("FAIL mid_wadr: adr_we=%b d=%h want 00010 7100", pio_adr_we, pio_d);
    end
    cfg_nch = 0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pio_adr_we !== 0 || pio_len_we !== 0 || pio_d !== 0 || busy !== 0 || nch !== 0 ||
        cmpl_val !== 0) begin
      errors++;
      $display("FAIL mid_reset: adr_we=%b len_we=%b d=%h busy=%b nch=%0d cv=%b want all 0",
               pio_adr_we, pio_len_we, pio_d, busy, nch, cmpl_val);
    end
    tick;
    rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (pio_adr_we !== 0 || busy !== 0) quiet = 0;
    end
    vectors++;
    if (!quiet || dif.desc_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_flush: activity=%0d rdy=%b want no activity, rdy 1", !quiet,
               dif.desc_rdy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.desc_val = 1'b0;
    dif.desc_ch  = '0;
    dif.desc_adr = '0;
    dif.desc_len = '0;
    cfg_nch      = '0;
    done         = '0;
    err          = '0;
    tick;
    tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_basic;
    test_round_robin;
    test_queue_full;
    test_drops;
    test_nch_update;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
